// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with an in-order prefetch FIFO.
// Optional same-cycle response bypass is enabled by defining FETCH_BYPASS_EN.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h66000000,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            fetch_en_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [XLEN-1:0] fi_instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] fi_pc_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   dis_q, dis_d;

  logic [CW:0]     inflight;
  logic [XLEN-1:0] tgt;
  logic            grant;
  logic            rsp;
  logic            keep;
  logic            byp;
  logic            empty;
  logic            push;
  logic            pop;

  assign inflight = {1'b0, cnt_q} + {1'b0, out_q};
  assign tgt      = {redirect_addr_i[XLEN-1:2], 2'b00};
  assign empty    = (cnt_q == '0);

  assign imem_req_o  = fetch_en_i & ~redirect_i
                     & (inflight < DEPTH_W);
  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o & imem_gnt_i;

  // A response only counts if something is in flight.
  assign rsp  = imem_rvalid_i & (out_q != '0);
  assign keep = rsp & (dis_q == '0) & ~redirect_i;

`ifdef FETCH_BYPASS_EN
  assign byp = keep & empty;
`else
  assign byp = 1'b0;
`endif

  assign push = keep & ~(byp & instr_ready_i);
  assign pop  = ~empty & instr_ready_i & ~redirect_i;

  // Decoder view: FIFO head, else bypassed response, else zero.
  always_comb begin
    instr_valid_o = ~empty | byp;
    instr_o       = '0;
    instr_pc_o    = '0;
    if (!empty) begin
      instr_o    = fi_instr_q[rptr_q];
      instr_pc_o = fi_pc_q[rptr_q];
    end else if (byp) begin
      instr_o    = imem_rdata_i;
      instr_pc_o = rpc_q;
    end
  end

  // Next state for PCs, credit counters and FIFO pointers.
  always_comb begin
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    dis_d  = dis_q;
    out_d  = out_q + CW'(grant) - CW'(rsp);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (grant) begin
      pc_d = pc_q + XLEN'(4);
    end
    if (keep) begin
      rpc_d = rpc_q + XLEN'(4);
    end
    if (rsp && (dis_q != '0)) begin
      dis_d = dis_q - CW'(1);
    end
    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    if (redirect_i) begin
      pc_d   = tgt;
      rpc_d  = tgt;
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
      dis_d  = out_d;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_q   <= RESET_VECTOR;
      rpc_q  <= RESET_VECTOR;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      dis_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      dis_q  <= dis_d;
    end
  end

  // FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fi_instr_q[wptr_q] <= imem_rdata_i;
      fi_pc_q[wptr_q]    <= rpc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tables plus random traffic against
// a stream-level model of the fetch unit.
module tb_fetch_unit;

  localparam logic [31:0] RV    = 32'h66000000;
  localparam int          DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  fetch_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .fetch_en_i(fetch_en_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  typedef struct {
    logic        en;
    logic        gnt;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  int          n_tests = 0;
  int          n_fail = 0;
  rsp_t        memq[$];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] exp_pc = RV;
  logic [31:0] exp_req = RV;
  logic        en_v = 0, gnt_v = 0, rdy_v = 0;
  logic        redir_v = 0, stray_v = 0;
  logic [31:0] tgt_v = '0;
  logic        s_req, s_valid, s_rvalid;
  logic [31:0] s_addr;
  int          acc_cnt = 0;
  int          grants = 0;
  logic [31:0] acc_pcs[$];
  vec_t        tbl[10];

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic gnt,
                        input logic rdy);
    en_v    = en;
    gnt_v   = gnt;
    rdy_v   = rdy;
    redir_v = 1'b0;
    stray_v = 1'b0;
  endtask

  // One clock: drive, sample, score, advance memory model.
  task automatic cycle();
    logic from_mem;
    @(negedge clk);
    fetch_en_i      = en_v;
    imem_gnt_i      = gnt_v;
    instr_ready_i   = rdy_v;
    redirect_i      = redir_v;
    redirect_addr_i = tgt_v;
    from_mem = (memq.size() > 0) && (memq[0].due <= cyc);
    if (from_mem) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = hash(memq[0].addr);
    end else if (stray_v && memq.size() == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = $urandom;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    s_req    = imem_req_o;
    s_addr   = imem_addr_o;
    s_valid  = instr_valid_o;
    s_rvalid = imem_rvalid_i;
    if (redir_v) begin
      check("req_in_redirect", 32'(imem_req_o), 0);
      exp_pc  = {tgt_v[31:2], 2'b00};
      exp_req = {tgt_v[31:2], 2'b00};
    end else if (instr_valid_o && rdy_v) begin
      check("instr_pc", instr_pc_o, exp_pc);
      check("instr_data", instr_o, hash(exp_pc));
      acc_pcs.push_back(instr_pc_o);
      acc_cnt++;
      exp_pc += 32'd4;
    end
    if (from_mem) begin
      void'(memq.pop_front());
    end
    if (imem_req_o && gnt_v) begin
      check("req_addr", imem_addr_o, exp_req);
      exp_req += 32'd4;
      grants++;
      memq.push_back('{imem_addr_o, cyc + lat});
      check("credit", 32'(memq.size() <= DEPTH), 1);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n         = 1'b0;
    fetch_en_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i    = 1'b0;
    #1;
    check("rst_req", 32'(imem_req_o), 0);
    check("rst_addr", imem_addr_o, RV);
    check("rst_valid", 32'(instr_valid_o), 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", instr_pc_o, 0);
    memq.delete();
    exp_pc  = RV;
    exp_req = RV;
    lat     = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1, 1, 1, 1, 32'h66000000};
    tbl[1] = '{1, 1, 1, 1, 32'h66000004};
    tbl[2] = '{1, 0, 1, 1, 32'h66000008};
    tbl[3] = '{1, 0, 1, 1, 32'h66000008};
    tbl[4] = '{1, 0, 1, 1, 32'h66000008};
    tbl[5] = '{1, 1, 1, 1, 32'h66000008};
    tbl[6] = '{1, 1, 1, 1, 32'h6600000C};
    tbl[7] = '{0, 1, 1, 0, 32'h66000010};
    tbl[8] = '{0, 1, 1, 0, 32'h66000010};
    tbl[9] = '{1, 1, 1, 1, 32'h66000010};

    // Stream start, grant stall and fetch disable.
    do_reset();
    acc_cnt = 0;
    acc_pcs.delete();
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].en, tbl[i].gnt, tbl[i].rdy);
      cycle();
      check($sformatf("tbl%0d_req", i), 32'(s_req),
            32'(tbl[i].exp_req));
      check($sformatf("tbl%0d_addr", i), s_addr,
            tbl[i].exp_addr);
    end
    set_in(0, 1, 1);
    repeat (4) cycle();
    check("tbl_acc_cnt", 32'(acc_cnt), 5);
    check("tbl_first_pc", acc_pcs[0], RV);

    // Steady state: one instruction per cycle.
    do_reset();
    acc_cnt = 0;
    set_in(1, 1, 1);
    repeat (10) cycle();
    check("steady_acc", 32'(acc_cnt), 32'(8 + BYP));

    // Backpressure: credits cap grants at FIFO_DEPTH.
    do_reset();
    grants = 0;
    set_in(1, 1, 0);
    repeat (8) cycle();
    check("bp_grants", 32'(grants), DEPTH);
    check("bp_req_off", 32'(s_req), 0);
    acc_cnt = 0;
    grants  = 0;
    set_in(1, 1, 1);
    repeat (10) cycle();
    check("bp_drain", 32'(acc_cnt >= DEPTH), 1);
    check("bp_resume", 32'(grants > 0), 1);

    // Redirect with one buffered entry and two in flight.
    do_reset();
    set_in(1, 1, 0);
    cycle();
    lat = 20;
    cycle();
    cycle();
    set_in(0, 1, 0);
    redir_v = 1'b1;
    tgt_v   = 32'h00000102;
    cycle();
    check("rd_req", 32'(s_req), 0);
    lat = 1;
    acc_pcs.delete();
    set_in(1, 1, 1);
    cycle();
    check("rd_flushed", 32'(s_valid), 0);
    check("rd_req_next", 32'(s_req), 1);
    check("rd_addr_next", s_addr, 32'h00000100);
    repeat (30) cycle();
    check("rd_first_pc",
          acc_pcs.size() > 0 ? acc_pcs[0] : 32'hxxxxxxxx,
          32'h00000100);

    // Address wrap at the top of memory.
    do_reset();
    set_in(1, 1, 1);
    redir_v = 1'b1;
    tgt_v   = 32'hFFFFFFFC;
    cycle();
    set_in(1, 1, 1);
    acc_pcs.delete();
    cycle();
    check("wrap_addr0", s_addr, 32'hFFFFFFFC);
    cycle();
    check("wrap_addr1", s_addr, 32'h00000000);
    repeat (4) cycle();
    check("wrap_pc0",
          acc_pcs.size() > 1 ? acc_pcs[0] : 32'hxxxxxxxx,
          32'hFFFFFFFC);
    check("wrap_pc1",
          acc_pcs.size() > 1 ? acc_pcs[1] : 32'hxxxxxxxx,
          32'h00000000);

    // Response-to-valid latency.
    do_reset();
    set_in(1, 1, 1);
    cycle();
    set_in(0, 1, 1);
    cycle();
    check("lat_rvalid", 32'(s_rvalid), 1);
    check("lat_same", 32'(s_valid), 32'(BYP));
    cycle();
    check("lat_next", 32'(s_valid), 32'(1 - BYP));

    // Random traffic with one asynchronous reset midway.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
      end
      en_v    = ($urandom % 8) != 0;
      gnt_v   = ($urandom % 4) != 0;
      rdy_v   = ($urandom % 3) != 0;
      redir_v = ($urandom % 20) == 0;
      stray_v = ($urandom % 10) == 0;
      tgt_v   = $urandom;
      lat     = 1 + int'($urandom % 4);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
